// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the MIPS fetch path: next-PC select codes,
// default reset/exception vectors and the 16-bit sign-extension helper.
package cpu_pkg;

   // Next-PC select codes driven by the control unit
   localparam logic [3:0] PC_CTRL_SEQ   = 4'b0000;
   localparam logic [3:0] PC_CTRL_J     = 4'b0001;
   localparam logic [3:0] PC_CTRL_JR    = 4'b0010;
   localparam logic [3:0] PC_CTRL_BR    = 4'b0011;
   localparam logic [3:0] PC_CTRL_JAL   = 4'b0100;
   localparam logic [3:0] PC_CTRL_JALR  = 4'b0101;
   localparam logic [3:0] PC_CTRL_RET   = 4'b0110;
   localparam logic [3:0] PC_CTRL_HOLD  = 4'b0111;
   localparam logic [3:0] PC_CTRL_ILL_8 = 4'b1000;
   localparam logic [3:0] PC_CTRL_ILL_9 = 4'b1001;
   localparam logic [3:0] PC_CTRL_ILL_A = 4'b1010;
   localparam logic [3:0] PC_CTRL_ILL_B = 4'b1011;
   localparam logic [3:0] PC_CTRL_ILL_C = 4'b1100;
   localparam logic [3:0] PC_CTRL_ILL_D = 4'b1101;
   localparam logic [3:0] PC_CTRL_ILL_E = 4'b1110;
   localparam logic [3:0] PC_CTRL_ILL_F = 4'b1111;

   // Default vectors, truncated to the PC width by the user
   localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_EXC_VECTOR_DEFAULT   = 32'h8000_0180;

   // Sign-extend a 16-bit immediate to 32 bits
   function automatic logic [31:0] sext16(input logic [15:0] value);
      return {{16{value[15]}}, value};
   endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; the caller never pops an empty stack.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, pop      stack operations (never both in one cycle)
//   push_data      address to push
//   top            entry at the top pointer
//   count          number of occupied entries (0..RAS_DEPTH)
module return_stack #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4,
   localparam int PTR_W    = $clog2(RAS_DEPTH),
   localparam int CNT_W    = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic [CNT_W-1:0]  count
);

   logic [ADDR_W-1:0] entries [RAS_DEPTH];
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  push_ptr;

   // The pointer wraps naturally because the depth is a power of two, so a
   // push on a full stack lands on the oldest slot.
   assign push_ptr = top_ptr + 1'b1;
   assign top      = entries[top_ptr];

   // Storage needs no reset: contents are only read when count says valid
   always_ff @(posedge clk) begin
      if (push) begin
         entries[push_ptr] <= push_data;
      end
   end

   // Pointer and occupancy; occupancy saturates at the depth on overwrite
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (push) begin
         top_ptr <= push_ptr;
         if (count != CNT_W'(RAS_DEPTH)) begin
            count <= count + 1'b1;
         end
      end else if (pop) begin
         top_ptr <= top_ptr - 1'b1;
         count   <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program counter for the MIPS fetch stage: sequential, jump, branch,
// link, return-stack returns, exception redirect with EPC capture and
// trapping of illegal codes / misaligned register targets.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   stall           hold PC and RAS this cycle
//   pc_control      next-PC select code
//   branch_taken    qualifies the conditional branch code
//   jump_address    J-type target field
//   branch_offset   signed word offset for branches
//   reg_address     register-sourced target
//   exception       external exception request (beats stall)
//   pc, pc_plus4    current fetch address and its successor / link value
//   link_we         one-cycle link write pulse for accepted JAL/JALR
//   epc             PC of the trapped or excepted instruction
//   ras_count       occupied return-stack entries
//   trap            one-cycle pulse for illegal code or misaligned target
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT,
   parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR_DEFAULT,
   parameter int          RAS_DEPTH    = 4,
   localparam int         CNT_W        = $clog2(RAS_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [3:0]        pc_control,
   input  logic              branch_taken,
   input  logic [25:0]       jump_address,
   input  logic [15:0]       branch_offset,
   input  logic [ADDR_W-1:0] reg_address,
   input  logic              exception,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              link_we,
   output logic [ADDR_W-1:0] epc,
   output logic [CNT_W-1:0]  ras_count,
   output logic              trap
);

   localparam logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VECTOR[ADDR_W-1:0];

   logic [31:0]       pc_plus4_ext;
   logic [31:0]       jump_full;
   logic [31:0]       branch_full;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] pc_next;
   logic              misaligned;
   logic              illegal;
   logic              push_req;
   logic              pop_req;
   logic              link_req;
   logic              accept;

   assign pc_plus4 = pc + ADDR_W'(4);

   // Targets are formed at 32 bits and truncated, which keeps the
   // ADDR_W=28 case (no upper region bits) legal and wraps silently.
   assign pc_plus4_ext  = 32'(pc_plus4);
   assign jump_full     = {pc_plus4_ext[31:28], jump_address, 2'b00};
   assign branch_full   = pc_plus4_ext + (sext16(branch_offset) << 2);
   assign jump_target   = jump_full[ADDR_W-1:0];
   assign branch_target = branch_full[ADDR_W-1:0];
   assign misaligned    = (reg_address[1:0] != 2'b00);

   // Only a normal (non-exception, non-stalled) edge may touch the RAS
   assign accept = !exception && !stall;

   // Next-PC select. A misaligned register target is treated exactly like an
   // illegal code, and suppresses the push/link of a JALR.
   always_comb begin
      pc_next  = pc_plus4;
      illegal  = 1'b0;
      push_req = 1'b0;
      pop_req  = 1'b0;
      link_req = 1'b0;
      case (pc_control)
         PC_CTRL_SEQ:  pc_next = pc_plus4;
         PC_CTRL_J:    pc_next = jump_target;
         PC_CTRL_JR: begin
            if (misaligned) illegal = 1'b1;
            else            pc_next = reg_address;
         end
         PC_CTRL_BR:   pc_next = branch_taken ? branch_target : pc_plus4;
         PC_CTRL_JAL: begin
            pc_next  = jump_target;
            push_req = 1'b1;
            link_req = 1'b1;
         end
         PC_CTRL_JALR: begin
            if (misaligned) begin
               illegal = 1'b1;
            end else begin
               pc_next  = reg_address;
               push_req = 1'b1;
               link_req = 1'b1;
            end
         end
         PC_CTRL_RET: begin
            if (ras_count != '0) begin
               pc_next = ras_top;
               pop_req = 1'b1;
            end else if (misaligned) begin
               illegal = 1'b1;
            end else begin
               pc_next = reg_address;
            end
         end
         PC_CTRL_HOLD: pc_next = pc;
         PC_CTRL_ILL_8, PC_CTRL_ILL_9, PC_CTRL_ILL_A, PC_CTRL_ILL_B,
         PC_CTRL_ILL_C, PC_CTRL_ILL_D, PC_CTRL_ILL_E, PC_CTRL_ILL_F:
            illegal = 1'b1;
         default:      illegal = 1'b1;
      endcase
      if (illegal) begin
         pc_next = EXC_PC;
      end
   end

   return_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (accept && push_req),
      .pop       (accept && pop_req),
      .push_data (pc_plus4),
      .top       (ras_top),
      .count     (ras_count)
   );

   // PC, EPC and the registered pulses. Exception outranks stall, which
   // outranks the control code; a stalled code is dropped, not queued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         epc     <= '0;
         link_we <= 1'b0;
         trap    <= 1'b0;
      end else if (exception) begin
         pc      <= EXC_PC;
         epc     <= pc;
         link_we <= 1'b0;
         trap    <= 1'b0;
      end else if (stall) begin
         link_we <= 1'b0;
         trap    <= 1'b0;
      end else begin
         pc      <= pc_next;
         link_we <= link_req;
         trap    <= illegal;
         if (illegal) begin
            epc <= pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
   import cpu_pkg::*;

   localparam logic [31:0] EXC = 32'h8000_0180;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [3:0]  pc_control;
   logic        branch_taken;
   logic [25:0] jump_address;
   logic [15:0] branch_offset;
   logic [31:0] reg_address;
   logic        exception;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        link_we;
   logic [31:0] epc;
   logic [2:0]  ras_count;
   logic        trap;

   int assert_count = 0;
   int fail_count   = 0;

   logic [31:0] ret_expect [5];

   pc_sequencer #(
      .ADDR_W       (32),
      .RESET_VECTOR (32'h0),
      .EXC_VECTOR   (EXC),
      .RAS_DEPTH    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pc_control    (pc_control),
      .branch_taken  (branch_taken),
      .jump_address  (jump_address),
      .branch_offset (branch_offset),
      .reg_address   (reg_address),
      .exception     (exception),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .link_we       (link_we),
      .epc           (epc),
      .ras_count     (ras_count),
      .trap          (trap)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one control code and advance past the next rising edge
   task automatic applyStimulus(input logic [3:0] ctrl, input logic taken,
                                input logic [25:0] jaddr, input logic [15:0] boff,
                                input logic [31:0] raddr);
      pc_control    = ctrl;
      branch_taken  = taken;
      jump_address  = jaddr;
      branch_offset = boff;
      reg_address   = raddr;
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence
   initial begin
      rst = 1'b0;
      stall = 1'b0;
      exception = 1'b0;
      pc_control = PC_CTRL_SEQ;
      branch_taken = 1'b0;
      jump_address = '0;
      branch_offset = '0;
      reg_address = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pc", pc, 32'h0);
      checkOutput("reset_epc", epc, 32'h0);
      checkOutput("reset_cnt", 32'(ras_count), 32'd0);
      checkOutput("reset_link", 32'(link_we), 32'd0);
      checkOutput("reset_trap", 32'(trap), 32'd0);
      rst = 1'b1;

      // Sequential fetch
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(PC_CTRL_SEQ, 1'b0, '0, '0, '0);
         checkOutput("seq_pc", pc, 32'(4 * i));
         checkOutput("seq_trap", 32'(trap), 32'd0);
         checkOutput("seq_cnt", 32'(ras_count), 32'd0);
      end
      checkOutput("pc_plus4", pc_plus4, 32'd16);

      // Software hold
      applyStimulus(PC_CTRL_HOLD, 1'b0, '0, '0, '0);
      checkOutput("hold_pc", pc, 32'd12);

      // Branch taken with negative offset, then not taken
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h0040_0010);
      checkOutput("jr_pc", pc, 32'h0040_0010);
      applyStimulus(PC_CTRL_BR, 1'b1, '0, 16'hFFFE, '0);
      checkOutput("br_taken", pc, 32'h0040_000C);
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h0040_0010);
      applyStimulus(PC_CTRL_BR, 1'b0, '0, 16'hFFFE, '0);
      checkOutput("br_not_taken", pc, 32'h0040_0014);

      // Nested calls and returns
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h100);
      applyStimulus(PC_CTRL_JAL, 1'b0, 26'h100, '0, '0);
      checkOutput("jal1_pc", pc, 32'h400);
      checkOutput("jal1_link", 32'(link_we), 32'd1);
      checkOutput("jal1_cnt", 32'(ras_count), 32'd1);
      applyStimulus(PC_CTRL_JAL, 1'b0, 26'h200, '0, '0);
      checkOutput("jal2_pc", pc, 32'h800);
      checkOutput("jal2_link", 32'(link_we), 32'd1);
      checkOutput("jal2_cnt", 32'(ras_count), 32'd2);
      applyStimulus(PC_CTRL_RET, 1'b0, '0, '0, 32'h0);
      checkOutput("ret1_pc", pc, 32'h404);
      checkOutput("ret1_link", 32'(link_we), 32'd0);
      checkOutput("ret1_cnt", 32'(ras_count), 32'd1);
      applyStimulus(PC_CTRL_RET, 1'b0, '0, '0, 32'h0);
      checkOutput("ret2_pc", pc, 32'h104);
      checkOutput("ret2_cnt", 32'(ras_count), 32'd0);

      // Overflow: five calls into a four-deep stack
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h1000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(PC_CTRL_JAL, 1'b0, 26'((32'h3000 + 32'(i) * 32'h100) >> 2), '0, '0);
         checkOutput("ovf_jal_pc", pc, 32'h3000 + 32'(i) * 32'h100);
         checkOutput("ovf_jal_cnt", 32'(ras_count), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      ret_expect[0] = 32'h3304;
      ret_expect[1] = 32'h3204;
      ret_expect[2] = 32'h3104;
      ret_expect[3] = 32'h3004;
      ret_expect[4] = 32'h2000;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(PC_CTRL_RET, 1'b0, '0, '0, 32'h2000);
         checkOutput("ovf_ret_pc", pc, ret_expect[i]);
         checkOutput("ovf_ret_cnt", 32'(ras_count), (i < 4) ? 32'(3 - i) : 32'd0);
      end

      // Illegal code trap
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h50);
      applyStimulus(PC_CTRL_ILL_A, 1'b0, '0, '0, '0);
      checkOutput("ill_pc", pc, EXC);
      checkOutput("ill_epc", epc, 32'h50);
      checkOutput("ill_trap", 32'(trap), 32'd1);
      applyStimulus(PC_CTRL_SEQ, 1'b0, '0, '0, '0);
      checkOutput("ill_trap_end", 32'(trap), 32'd0);
      checkOutput("ill_after_pc", pc, EXC + 32'd4);

      // Misaligned JR trap
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h1002);
      checkOutput("mis_pc", pc, EXC);
      checkOutput("mis_epc", epc, EXC + 32'd4);
      checkOutput("mis_trap", 32'(trap), 32'd1);

      // Stall with a pending JAL must change nothing
      applyStimulus(PC_CTRL_JR, 1'b0, '0, '0, 32'h600);
      applyStimulus(PC_CTRL_JAL, 1'b0, 26'(32'h700 >> 2), '0, '0);
      checkOutput("pre_stall_cnt", 32'(ras_count), 32'd1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(PC_CTRL_JAL, 1'b0, 26'h10, '0, '0);
         checkOutput("stall_pc", pc, 32'h700);
         checkOutput("stall_cnt", 32'(ras_count), 32'd1);
         checkOutput("stall_link", 32'(link_we), 32'd0);
      end

      // Exception beats stall
      exception = 1'b1;
      applyStimulus(PC_CTRL_JAL, 1'b0, 26'h10, '0, '0);
      checkOutput("exc_pc", pc, EXC);
      checkOutput("exc_epc", epc, 32'h700);
      checkOutput("exc_cnt", 32'(ras_count), 32'd1);
      checkOutput("exc_trap", 32'(trap), 32'd0);
      exception = 1'b0;
      stall = 1'b0;

      // Asynchronous reset in the middle of a JAL
      pc_control = PC_CTRL_JAL;
      jump_address = 26'h40;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("async_rst_pc", pc, 32'h0);
      checkOutput("async_rst_cnt", 32'(ras_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(PC_CTRL_SEQ, 1'b0, '0, '0, '0);
      checkOutput("resume_pc", pc, 32'h4);
      checkOutput("resume_cnt", 32'(ras_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
